// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, shared by the
// ALU and load/multicycle writeback paths, plus a sequencer that clears all registers.
module regfile_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int NREG   = 16,
  parameter int SEL_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0_valid,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req0_dat,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [DATA_W-1:0] req1_dat,
  output logic              req1_ready,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              WEN,
  output logic [SEL_W-1:0]  wsel,
  output logic [DATA_W-1:0] wdat
);

  localparam int CNT_W = SEL_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NREG - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    count_nxt;
  logic                last_grant_q, last_grant_d;
  logic                wen_q, wen_d;
  logic [SEL_W-1:0]    wsel_q, wsel_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic                clr_done_q, clr_done_d;
  logic                gnt0, gnt1;

  // Grants only in IDLE with no clear request; last_grant=1 means req1 won last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!RST && state_q == S_IDLE && !clr_start) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant_q;
        gnt1 = !last_grant_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign count_nxt = count_q + CNT_W'(1);

  // count holds the index of the clear write currently on the port.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    wen_d        = 1'b0;
    wsel_d       = wsel_q;
    wdat_d       = wdat_q;
    clr_done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          state_d = S_CLEAR;
          count_d = '0;
          wen_d   = 1'b1;
          wsel_d  = '0;
          wdat_d  = '0;
        end else if (gnt0) begin
          wen_d        = 1'b1;
          wsel_d       = req0_sel;
          wdat_d       = req0_dat;
          last_grant_d = 1'b0;
        end else if (gnt1) begin
          wen_d        = 1'b1;
          wsel_d       = req1_sel;
          wdat_d       = req1_dat;
          last_grant_d = 1'b1;
        end
      end
      S_CLEAR: begin
        if (count_q == LAST_IDX) begin
          state_d    = S_IDLE;
          count_d    = '0;
          clr_done_d = 1'b1;
        end else begin
          count_d = count_nxt;
          wen_d   = 1'b1;
          wsel_d  = count_nxt[SEL_W-1:0];
          wdat_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      wen_q        <= 1'b0;
      wsel_q       <= '0;
      wdat_q       <= '0;
      clr_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      wen_q        <= wen_d;
      wsel_q       <= wsel_d;
      wdat_q       <= wdat_d;
      clr_done_q   <= clr_done_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign clr_busy   = (state_q == S_CLEAR);
  assign clr_done   = clr_done_q;
  assign WEN        = wen_q;
  assign wsel       = wsel_q;
  assign wdat       = wdat_q;

endmodule
